seg7_scan_driver: RTL
=====================

// Module: seg7_scan_driver
// PURPOSE
//  Time-multiplexed scan driver feeding seg7decoder's SEG_SELECT_IN/BIN_IN/DOT_IN.
//  Accepts a 4-digit hex value + 4 dot bits over a load/ready handshake.
//  Double-buffers it and rotates through digits 0..3 at a fixed refresh rate.
//  Sits in top between system logic and seg7decoder; runs on clk_sys.
// PARAMETERS
//  REFRESH_DIV  100000  clk_sys cycles per digit (1 kHz/digit @100 MHz); legal >= 2
//  CNT_W        17      refresh counter width; must hold REFRESH_DIV-1
// PORTS
//  CLK_IN          in   1   clk_sys; single clock domain
//  RESET_IN        in   1   asynchronous, active-high reset
//  DATA_IN         in   16  hex value; nibble d -> digit d (digit 0 = rightmost)
//  DOTS_IN         in   4   dot bit d -> digit d
//  LOAD_IN         in   1   request to capture DATA_IN/DOTS_IN
//  READY_OUT       out  1   1 = shadow buffer free, load accepted
//  SEG_SELECT_OUT  out  2   digit index to seg7decoder
//  BIN_OUT         out  4   nibble for current digit
//  DOT_OUT         out  1   dot for current digit
//  BLANK_OUT       out  1   1 = current digit must be dark (top gates anodes)
// BEHAVIOUR
//  Reset (async, while RESET_IN=1): cnt=0, digit=0, active/shadow regs=0,
//   pending=0; READY_OUT=1, SEG_SELECT_OUT=0, BIN_OUT=0, DOT_OUT=0, BLANK_OUT=0.
//  Refresh counter: cnt 0..REFRESH_DIV-1, wraps to 0; tick=1 when cnt==REFRESH_DIV-1.
//  On tick: digit <= digit+1 (3 wraps to 0). All four display outputs are
//   registered from the NEW digit index and change together 1 cycle after tick.
//  Frame boundary = tick while digit==3 (next digit 0).
//  Handshake: accept = LOAD_IN & READY_OUT. On accept: shadow <= {DOTS_IN,DATA_IN},
//   pending <= 1, READY_OUT <= 0 next cycle. LOAD_IN while READY_OUT=0: ignored.
//  On frame boundary with pending=1: active <= shadow, pending <= 0, READY_OUT=1
//   next cycle. The digit-0 outputs of that same edge already use the new
//   value (no torn frame: all 4 digits of a frame come from one load).
//  Simultaneous accept and frame boundary (pending=0): capture into shadow;
//   transfer to active occurs at the following boundary, not this one.
//  Load with pending=0 never changes displayed digits mid-frame.
//  Worst-case load-to-display latency: 4*REFRESH_DIV+1 cycles.
//  BIN_OUT = active[4*d+3:4*d], DOT_OUT = active_dots[d], SEG_SELECT_OUT = d.
//  RESET_IN mid-frame: outputs/state return to reset values immediately;
//   pending load discarded; scanning restarts at digit 0, cnt 0 after release.
// CONFIGURATION
//  SEG7_LZ_BLANK_EN defined: leading-zero blanking. BLANK_OUT=1 for digit d (d>=1)
//   when nibbles d..3 are all 0 AND dots d..3 are all 0. Digit 0 never blanked.
//   Registered with the other display outputs (same cycle).
//  SEG7_LZ_BLANK_EN undefined: BLANK_OUT tied 0; all digits always shown.
// TESTING (bench uses REFRESH_DIV=4)
//  1 Release reset -> READY_OUT=1, SEG_SELECT_OUT 0,1,2,3,0 each held 4 cycles,
//    BIN_OUT=0, DOT_OUT=0 throughout.
//  2 Load 16'h1234, dots 4'b0010 at digit 1 -> READY_OUT=0 next cycle; digits 2,3
//    still show 0; next frame: d0 BIN=4, d1 BIN=3 DOT=1, d2 BIN=2, d3 BIN=1;
//    READY_OUT=1 one cycle after boundary.
//  3 While READY_OUT=0 pulse LOAD_IN with 16'hFFFF -> ignored; F never displayed.
//  4 Load 16'hABCD then assert RESET_IN mid-frame -> all outputs 0 same cycle,
//    READY_OUT=1; after release display shows 0, not ABCD.
//  5 SEG7_LZ_BLANK_EN defined, load 16'h0042 dots 0 -> BLANK_OUT=1 on d3,d2,
//    0 on d1,d0; load 16'h0000 -> blanked d3..d1, d0 shows 0; macro undefined
//    -> BLANK_OUT=0 always.
//  6 LOAD_IN asserted on the boundary edge (pending=0) -> value appears exactly
//    one frame later; no digit of the current frame changes.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: double-buffered 4-digit hex scan driver feeding seg7decoder.
// Define SEG7_LZ_BLANK_EN to enable leading-zero blanking on BLANK_OUT.
module seg7_scan_driver #(
  parameter int REFRESH_DIV = 100000,
  parameter int CNT_W       = 17
) (
  input  logic        CLK_IN,
  input  logic        RESET_IN,
  input  logic [15:0] DATA_IN,
  input  logic [3:0]  DOTS_IN,
  input  logic        LOAD_IN,
  output logic        READY_OUT,
  output logic [1:0]  SEG_SELECT_OUT,
  output logic [3:0]  BIN_OUT,
  output logic        DOT_OUT,
  output logic        BLANK_OUT
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_digit;
  logic [19:0]      r_active;
  logic [19:0]      r_shadow;
  logic             r_pending;
  logic [1:0]       r_sel;
  logic [3:0]       r_bin;
  logic             r_dot;
  logic             r_blank;

  logic             w_tick;
  logic             w_boundary;
  logic             w_accept;
  logic             w_transfer;
  logic [1:0]       w_nextDigit;
  logic [19:0]      w_nextActive;
  logic [15:0]      w_nextData;
  logic [3:0]       w_nextDots;
  logic             w_blank;

  assign w_tick       = (r_cnt == CNT_MAX);
  assign w_boundary   = w_tick && (r_digit == 2'd3);
  assign w_accept     = LOAD_IN && !r_pending;
  assign w_transfer   = w_boundary && r_pending;
  assign w_nextDigit  = r_digit + 2'd1;
  // Digit-0 outputs of the boundary edge must already see the newly promoted frame.
  assign w_nextActive = w_transfer ? r_shadow : r_active;
  assign w_nextData   = w_nextActive[15:0];
  assign w_nextDots   = w_nextActive[19:16];

`ifdef SEG7_LZ_BLANK_EN
  logic [3:0] w_nz;

  always_comb begin
    w_nz = 4'b0000;
    for (int d = 0; d < 4; d++) begin
      w_nz[d] = (w_nextData[4*d +: 4] != 4'h0) || w_nextDots[d];
    end
  end

  // Blank when this digit and every more-significant one carries nothing visible.
  assign w_blank = (w_nextDigit != 2'd0) && ((w_nz >> w_nextDigit) == 4'b0000);
`else
  assign w_blank = 1'b0;
`endif

  always_ff @(posedge CLK_IN or posedge RESET_IN) begin
    if (RESET_IN) begin
      r_cnt   <= '0;
      r_digit <= 2'd0;
    end else begin
      r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
      if (w_tick) begin
        r_digit <= w_nextDigit;
      end
    end
  end

  always_ff @(posedge CLK_IN or posedge RESET_IN) begin
    if (RESET_IN) begin
      r_active  <= 20'h0;
      r_shadow  <= 20'h0;
      r_pending <= 1'b0;
    end else if (w_transfer) begin
      r_active  <= r_shadow;
      r_pending <= 1'b0;
    end else if (w_accept) begin
      r_shadow  <= {DOTS_IN, DATA_IN};
      r_pending <= 1'b1;
    end
  end

  always_ff @(posedge CLK_IN or posedge RESET_IN) begin
    if (RESET_IN) begin
      r_sel   <= 2'd0;
      r_bin   <= 4'h0;
      r_dot   <= 1'b0;
      r_blank <= 1'b0;
    end else if (w_tick) begin
      r_sel   <= w_nextDigit;
      r_bin   <= w_nextData[{w_nextDigit, 2'b00} +: 4];
      r_dot   <= w_nextDots[w_nextDigit];
      r_blank <= w_blank;
    end
  end

  assign READY_OUT      = !r_pending;
  assign SEG_SELECT_OUT = r_sel;
  assign BIN_OUT        = r_bin;
  assign DOT_OUT        = r_dot;
  assign BLANK_OUT      = r_blank;

endmodule
